// File: rtl/sync_fifo_fwft_pkg.sv
// Shared definitions for the single-clock FIFO: pointer/level width helper
// and the read-mode selector values.
package sync_fifo_fwft_pkg;

   // Read-mode selector values for the FWFT parameter
   localparam int unsigned FWFT_STD = 0;   // data one cycle after rd_en
   localparam int unsigned FWFT_ON  = 1;   // head word presented before rd_en

   // Pointers and level carry one extra bit so full (DEPTH) is representable
   function automatic int unsigned ptr_width(input int unsigned depth_width);
      return depth_width + 1;
   endfunction

endpackage : sync_fifo_fwft_pkg

// File: rtl/sync_fifo_ram.sv
// Inferred simple dual-port RAM with a registered, enabled read port.
// The read register has reset and synchronous clear so it can serve
// directly as the FIFO output register.
//   clk_i     clock, rising edge
//   rst_ni    asynchronous active-low reset (read register only)
//   clr_i     synchronous clear of the read register
//   wr_en_i   write strobe, wr_addr_i / wr_data_i
//   rd_en_i   read strobe, rd_addr_i; rd_data_o updates after the edge
module sync_fifo_ram #(
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clr_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic [DATA_WIDTH-1:0] rd_data_d;

   // Storage array: no reset so it maps onto block RAM
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Read register next value; same-address read-during-write returns old data
   always_comb begin
      rd_data_d = rd_data_q;
      if (clr_i) begin
         rd_data_d = '0;
      end else if (rd_en_i) begin
         rd_data_d = mem_q[rd_addr_i];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data_o = rd_data_q;

endmodule : sync_fifo_ram

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable first-word-fall-through read, unified
// water level, registered flags, sticky overflow/underflow and sync flush.
//   clk, rst_n            clock and asynchronous active-low reset
//   clr                   synchronous flush (priority over wr_en/rd_en)
//   wr_data, wr_en        write side; wr_full, almost_full status
//   rd_en, rd_data        read side; rd_empty, almost_empty status
//   water_level           words held, including the FWFT output word
//   overflow, underflow   sticky error flags
module sync_fifo_fwft
   import sync_fifo_fwft_pkg::*;
#(
   parameter int unsigned DATA_WIDTH       = 24,
   parameter int unsigned DEPTH_WIDTH      = 8,
   parameter int unsigned FWFT             = FWFT_STD,
   parameter int unsigned ALMOST_FULL_NUM  = 252,
   parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_en,
   output logic                  wr_full,
   output logic                  almost_full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_empty,
   output logic                  almost_empty,
   output logic [DEPTH_WIDTH:0]  water_level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned PTR_W = ptr_width(DEPTH_WIDTH);
   localparam int unsigned DEPTH = 32'd1 << DEPTH_WIDTH;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] level_q,  level_d;
   logic             valid_q,  valid_d;
   logic             wr_full_q, wr_full_d;
   logic             almost_full_q, almost_full_d;
   logic             rd_empty_q, rd_empty_d;
   logic             almost_empty_q, almost_empty_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic             wr_accept;
   logic             rd_accept;
   logic             ram_empty;
   logic             ram_rd_en;

   // Next-state: pointers, level, output-stage valid, flags
   always_comb begin
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      level_d        = level_q;
      valid_d        = valid_q;
      overflow_d     = overflow_q;
      underflow_d    = underflow_q;

      wr_accept = wr_en && !wr_full_q && !clr;
      rd_accept = rd_en && !rd_empty_q && !clr;
      ram_empty = (wr_ptr_q == rd_ptr_q);

      // FWFT prefetches from registered RAM state, so a same-cycle write
      // never bypasses into the output word
      if (FWFT == FWFT_ON) begin
         ram_rd_en = !clr && !ram_empty && (!valid_q || rd_accept);
      end else begin
         ram_rd_en = rd_accept;
      end

      if (clr) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         valid_d     = 1'b0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (ram_rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({wr_accept, rd_accept})
            2'b10:   level_d = level_q + PTR_W'(1);
            2'b01:   level_d = level_q - PTR_W'(1);
            default: level_d = level_q;
         endcase
         if (FWFT == FWFT_ON) begin
            if (ram_rd_en) begin
               valid_d = 1'b1;
            end else if (rd_accept) begin
               valid_d = 1'b0;
            end
         end
         if (wr_en && wr_full_q) begin
            overflow_d = 1'b1;
         end
         if (rd_en && rd_empty_q) begin
            underflow_d = 1'b1;
         end
      end

      // Flags derive from the next level so they change with water_level
      wr_full_d      = (level_d == PTR_W'(DEPTH));
      almost_full_d  = (level_d >= PTR_W'(ALMOST_FULL_NUM));
      almost_empty_d = (level_d <= PTR_W'(ALMOST_EMPTY_NUM));
      if (FWFT == FWFT_ON) begin
         rd_empty_d = !valid_d;
      end else begin
         rd_empty_d = (level_d == '0);
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         level_q        <= '0;
         valid_q        <= 1'b0;
         wr_full_q      <= 1'b0;
         almost_full_q  <= 1'b0;
         rd_empty_q     <= 1'b1;
         almost_empty_q <= 1'b1;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         level_q        <= level_d;
         valid_q        <= valid_d;
         wr_full_q      <= wr_full_d;
         almost_full_q  <= almost_full_d;
         rd_empty_q     <= rd_empty_d;
         almost_empty_q <= almost_empty_d;
         overflow_q     <= overflow_d;
         underflow_q    <= underflow_d;
      end
   end

   // RAM read register doubles as the output word in both modes
   sync_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (DEPTH_WIDTH)
   ) u_ram (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .clr_i     (clr),
      .wr_en_i   (wr_accept),
      .wr_addr_i (wr_ptr_q[DEPTH_WIDTH-1:0]),
      .wr_data_i (wr_data),
      .rd_en_i   (ram_rd_en),
      .rd_addr_i (rd_ptr_q[DEPTH_WIDTH-1:0]),
      .rd_data_o (rd_data)
   );

   assign wr_full      = wr_full_q;
   assign almost_full  = almost_full_q;
   assign rd_empty     = rd_empty_q;
   assign almost_empty = almost_empty_q;
   assign water_level  = level_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule : sync_fifo_fwft
